// File: rtl/exc_pkg.sv
// Shared definitions for the exception responder and its neighbours.
// Holds the responder state encoding, the cause (syndrome) codes that are
// also used by the main decoder and the datapath, and the default handler
// entry address.
package exc_pkg;

   typedef enum logic [2:0] {
      RUN,
      ENTER,
      HANDLER,
      RETURN,
      LOCKUP
   } exc_state_t;

   localparam logic [3:0] ES_NONE  = 4'b0000;
   localparam logic [3:0] ES_IRQ   = 4'b0001;
   localparam logic [3:0] ES_UNDEF = 4'b0010;

   localparam logic [63:0] VECTOR_DEFAULT = 64'h0000_0000_0000_00D8;

endpackage

// File: rtl/exc_ctrl.sv
// Exception responder: sequences entry to and return from the exception
// handler, based on the decoder's Exc/EStatus outputs.
//
// Ports:
//   clk, reset       rising-edge clock, async active-low reset
//   Exc, EStatus     exception request and cause code from the decoder
//   PC_E             PC of the instruction currently being decoded
//   ERet             decoded exception-return instruction
//   ExtIRQ           raw level IRQ from the device
//   ExtIRQ_g         IRQ as seen by the decoder (masked outside RUN)
//   ExtIAck          one-cycle IRQ acknowledge, on entry for an IRQ cause
//   ExcTaken         one-cycle exception entry pulse
//   Redirect/NextPC  fetch redirect request and target
//   ELR, ESR         exception link and syndrome registers
//   InHandler        executing handler code (including return and lockup)
//   Halt             nested fault lockup, cleared only by reset
module exc_ctrl
   import exc_pkg::*;
#(
   parameter int unsigned    N      = 64,
   parameter logic [N-1:0]   VECTOR = N'(VECTOR_DEFAULT)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         Exc,
   input  logic [3:0]   EStatus,
   input  logic [N-1:0] PC_E,
   input  logic         ERet,
   input  logic         ExtIRQ,
   output logic         ExtIRQ_g,
   output logic         ExtIAck,
   output logic         ExcTaken,
   output logic         Redirect,
   output logic [N-1:0] NextPC,
   output logic [N-1:0] ELR,
   output logic [3:0]   ESR,
   output logic         InHandler,
   output logic         Halt
);

   exc_state_t   state_q, state_d;
   logic [N-1:0] elr_q, elr_d;
   logic [3:0]   esr_q, esr_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         elr_q   <= '0;
         esr_q   <= ES_NONE;
      end else begin
         state_q <= state_d;
         elr_q   <= elr_d;
         esr_q   <= esr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      elr_d     = elr_q;
      esr_d     = esr_q;
      ExtIAck   = 1'b0;
      ExcTaken  = 1'b0;
      Redirect  = 1'b0;
      NextPC    = '0;
      InHandler = 1'b0;
      Halt      = 1'b0;

      unique case (state_q)
         RUN: begin
            // ERet outside the handler is ignored.
            if (Exc) begin
               elr_d   = PC_E;
               esr_d   = EStatus;
               state_d = ENTER;
            end
         end
         ENTER: begin
            Redirect = 1'b1;
            NextPC   = VECTOR;
            ExcTaken = 1'b1;
            ExtIAck  = (esr_q == ES_IRQ);
            state_d  = HANDLER;
         end
         HANDLER: begin
            InHandler = 1'b1;
            // A fault inside the handler wins over ERET; ELR/ESR keep the
            // original cause for post-mortem inspection.
            if (Exc) begin
               state_d = LOCKUP;
            end else if (ERet) begin
               state_d = RETURN;
            end
         end
         RETURN: begin
            Redirect  = 1'b1;
            NextPC    = elr_q;
            InHandler = 1'b1;
            state_d   = RUN;
         end
         LOCKUP: begin
            Halt      = 1'b1;
            InHandler = 1'b1;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // Only IRQs seen in RUN reach the decoder; others stay pending at the device.
   assign ExtIRQ_g = ExtIRQ & (state_q == RUN);
   assign ELR      = elr_q;
   assign ESR      = esr_q;

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;

   localparam int unsigned  N   = 64;
   localparam logic [63:0]  VEC = 64'h0000_0000_0000_00D8;

   logic         clk = 1'b0;
   logic         reset;
   logic         Exc;
   logic [3:0]   EStatus;
   logic [N-1:0] PC_E;
   logic         ERet;
   logic         ExtIRQ;
   logic         ExtIRQ_g;
   logic         ExtIAck;
   logic         ExcTaken;
   logic         Redirect;
   logic [N-1:0] NextPC;
   logic [N-1:0] ELR;
   logic [3:0]   ESR;
   logic         InHandler;
   logic         Halt;

   int n_checks = 0;
   int n_fail   = 0;

   exc_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .Exc       (Exc),
      .EStatus   (EStatus),
      .PC_E      (PC_E),
      .ERet      (ERet),
      .ExtIRQ    (ExtIRQ),
      .ExtIRQ_g  (ExtIRQ_g),
      .ExtIAck   (ExtIAck),
      .ExcTaken  (ExcTaken),
      .Redirect  (Redirect),
      .NextPC    (NextPC),
      .ELR       (ELR),
      .ESR       (ESR),
      .InHandler (InHandler),
      .Halt      (Halt)
   );

   always #5 clk = ~clk;

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      Exc = 0; EStatus = 0; PC_E = 0; ERet = 0; ExtIRQ = 0;
      reset = 0;
      tick();
      tick();
      reset = 1;
      tick();
   endtask

   // Flags packed as {Redirect, ExcTaken, ExtIAck, InHandler, Halt}.
   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({Redirect, ExcTaken, ExtIAck, InHandler, Halt} !== 5'b00000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want 00000",
                  {Redirect, ExcTaken, ExtIAck, InHandler, Halt});
      end
      n_checks++;
      if (ELR !== 64'h0 || ESR !== 4'h0 || NextPC !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_regs: ELR=%h ESR=%h NextPC=%h want all 0", ELR, ESR, NextPC);
      end
      ExtIRQ = 1; #1;
      n_checks++;
      if (ExtIRQ_g !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_irq_g_hi: got %b want 1", ExtIRQ_g);
      end
      ExtIRQ = 0; #1;
      n_checks++;
      if (ExtIRQ_g !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_irq_g_lo: got %b want 0", ExtIRQ_g);
      end
   endtask

   task automatic test_undef_entry();
      do_reset();
      PC_E = 64'h40; Exc = 1; EStatus = 4'b0010;
      tick();
      Exc = 0; EStatus = 0; PC_E = 64'h999;
      n_checks++;
      if ({Redirect, ExcTaken, ExtIAck, InHandler, Halt} !== 5'b11000 || NextPC !== VEC) begin
         n_fail++;
         $display("FAIL undef_enter: flags=%b NextPC=%h want 11000 %h",
                  {Redirect, ExcTaken, ExtIAck, InHandler, Halt}, NextPC, VEC);
      end
      n_checks++;
      if (ELR !== 64'h40 || ESR !== 4'b0010) begin
         n_fail++;
         $display("FAIL undef_regs: ELR=%h ESR=%b want 40 0010", ELR, ESR);
      end
      tick();
      n_checks++;
      if ({Redirect, ExcTaken, ExtIAck, InHandler, Halt} !== 5'b00010) begin
         n_fail++;
         $display("FAIL undef_handler: flags=%b want 00010",
                  {Redirect, ExcTaken, ExtIAck, InHandler, Halt});
      end
   endtask

   task automatic test_irq_entry();
      do_reset();
      ExtIRQ = 1; PC_E = 64'h100; Exc = 1; EStatus = 4'b0001;
      tick();
      Exc = 0; EStatus = 0;
      n_checks++;
      if (ExtIAck !== 1'b1 || ESR !== 4'b0001 || ELR !== 64'h100 || ExtIRQ_g !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_enter: ack=%b ESR=%b ELR=%h irq_g=%b want 1 0001 100 0",
                  ExtIAck, ESR, ELR, ExtIRQ_g);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if (ExtIRQ_g !== 1'b0 || InHandler !== 1'b1 || ExtIAck !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_handler_gate[%0d]: irq_g=%b inh=%b ack=%b want 0 1 0",
                     i, ExtIRQ_g, InHandler, ExtIAck);
         end
      end
      ExtIRQ = 0;
   endtask

   task automatic test_eret();
      do_reset();
      PC_E = 64'h44; Exc = 1; EStatus = 4'b0010;
      tick();
      Exc = 0;
      tick();
      // ERet in the handler with ELR = 0x44.
      ERet = 1;
      tick();
      ERet = 0;
      n_checks++;
      if ({Redirect, ExcTaken, ExtIAck, InHandler, Halt} !== 5'b10010 || NextPC !== 64'h44) begin
         n_fail++;
         $display("FAIL eret_return: flags=%b NextPC=%h want 10010 44",
                  {Redirect, ExcTaken, ExtIAck, InHandler, Halt}, NextPC);
      end
      tick();
      n_checks++;
      if ({Redirect, InHandler} !== 2'b00 || ELR !== 64'h44 || ESR !== 4'b0010) begin
         n_fail++;
         $display("FAIL eret_run: redir=%b inh=%b ELR=%h ESR=%b want 0 0 44 0010",
                  Redirect, InHandler, ELR, ESR);
      end
      // ERet in RUN is ignored.
      ERet = 1;
      tick();
      ERet = 0;
      n_checks++;
      if ({Redirect, InHandler, Halt} !== 3'b000) begin
         n_fail++;
         $display("FAIL eret_in_run: redir=%b inh=%b halt=%b want 000",
                  Redirect, InHandler, Halt);
      end
   endtask

   task automatic test_nested_lockup();
      do_reset();
      PC_E = 64'h100; Exc = 1; EStatus = 4'b0001;
      tick();
      Exc = 0;
      tick();
      Exc = 1; EStatus = 4'b0010; ERet = 1; PC_E = 64'h208;
      tick();
      for (int i = 0; i < 4; i++) begin
         Exc = 1'($urandom); ERet = 1'($urandom); EStatus = 4'($urandom);
         n_checks++;
         if (Halt !== 1'b1 || Redirect !== 1'b0 || InHandler !== 1'b1 ||
             ELR !== 64'h100 || ESR !== 4'b0001) begin
            n_fail++;
            $display("FAIL lockup[%0d]: halt=%b redir=%b inh=%b ELR=%h ESR=%b want 1 0 1 100 0001",
                     i, Halt, Redirect, InHandler, ELR, ESR);
         end
         tick();
      end
      Exc = 0; ERet = 0;
   endtask

   task automatic test_async_reset();
      do_reset();
      ExtIRQ = 1; PC_E = 64'h300; Exc = 1; EStatus = 4'b0001;
      tick();
      Exc = 0;
      #2 reset = 0;
      #1;
      n_checks++;
      if ({Redirect, ExcTaken, ExtIAck} !== 3'b000 || ELR !== 64'h0 || ESR !== 4'h0) begin
         n_fail++;
         $display("FAIL async_reset: redir=%b taken=%b ack=%b ELR=%h ESR=%h want 000 0 0",
                  Redirect, ExcTaken, ExtIAck, ELR, ESR);
      end
      tick();
      reset = 1;
      tick();
      n_checks++;
      if (Redirect !== 1'b0 || InHandler !== 1'b0 || ExtIRQ_g !== 1'b1) begin
         n_fail++;
         $display("FAIL async_release: redir=%b inh=%b irq_g=%b want 0 0 1",
                  Redirect, InHandler, ExtIRQ_g);
      end
      ExtIRQ = 0;
   endtask

   // Random traffic against an event-level model of the responder.
   task automatic test_random();
      bit           m_entering, m_handler, m_returning, m_locked;
      logic [63:0]  m_elr;
      logic [3:0]   m_esr;
      logic [63:0]  exp_pc;
      logic [4:0]   exp_flags;
      bit           prev_redir, prev_taken, prev_ack;
      do_reset();
      m_entering = 0; m_handler = 0; m_returning = 0; m_locked = 0;
      m_elr = 0; m_esr = 0;
      prev_redir = 0; prev_taken = 0; prev_ack = 0;
      for (int c = 0; c < 600; c++) begin
         bit in_run, exc, eret;
         logic [3:0]  st;
         logic [63:0] pc;
         // Occasionally reset to escape lockup.
         if (m_locked && $urandom_range(0, 7) == 0) begin
            do_reset();
            m_entering = 0; m_handler = 0; m_returning = 0; m_locked = 0;
            m_elr = 0; m_esr = 0;
            prev_redir = 0; prev_taken = 0; prev_ack = 0;
         end
         exc  = ($urandom_range(0, 4) == 0);
         eret = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 3))
            0: st = 4'b0001;
            1: st = 4'b0010;
            default: st = 4'($urandom);
         endcase
         pc = {32'($urandom), 30'($urandom), 2'b00};
         Exc = exc; ERet = eret; EStatus = st; PC_E = pc; ExtIRQ = 1'($urandom);
         #1;
         in_run = !(m_entering || m_handler || m_returning || m_locked);
         n_checks++;
         if (ExtIRQ_g !== (ExtIRQ & in_run)) begin
            n_fail++;
            $display("FAIL rand_irq_g[%0d]: got %b want %b", c, ExtIRQ_g, ExtIRQ & in_run);
         end
         tick();
         // Model update for the edge just taken.
         if (m_locked) begin
            // absorbing
         end else if (m_entering) begin
            m_entering = 0; m_handler = 1;
         end else if (m_returning) begin
            m_returning = 0;
         end else if (m_handler) begin
            if (exc) begin
               m_handler = 0; m_locked = 1;
            end else if (eret) begin
               m_handler = 0; m_returning = 1;
            end
         end else if (exc) begin
            m_entering = 1; m_elr = pc; m_esr = st;
         end
         exp_pc = m_entering ? VEC : (m_returning ? m_elr : 64'h0);
         exp_flags = {m_entering | m_returning, m_entering, m_entering && (m_esr == 4'b0001),
                      m_handler | m_returning | m_locked, m_locked};
         n_checks++;
         if ({Redirect, ExcTaken, ExtIAck, InHandler, Halt} !== exp_flags) begin
            n_fail++;
            $display("FAIL rand_flags[%0d]: got %b want %b", c,
                     {Redirect, ExcTaken, ExtIAck, InHandler, Halt}, exp_flags);
         end
         n_checks++;
         if (NextPC !== exp_pc || ELR !== m_elr || ESR !== m_esr) begin
            n_fail++;
            $display("FAIL rand_regs[%0d]: NextPC=%h ELR=%h ESR=%b want %h %h %b",
                     c, NextPC, ELR, ESR, exp_pc, m_elr, m_esr);
         end
         n_checks++;
         if ((prev_redir && Redirect) || (prev_taken && ExcTaken) || (prev_ack && ExtIAck)) begin
            n_fail++;
            $display("FAIL rand_pulse_width[%0d]: redir=%b taken=%b ack=%b held two cycles",
                     c, Redirect, ExcTaken, ExtIAck);
         end
         prev_redir = Redirect; prev_taken = ExcTaken; prev_ack = ExtIAck;
      end
      Exc = 0; ERet = 0;
   endtask

   initial begin
      reset = 0; Exc = 0; EStatus = 0; PC_E = 0; ERet = 0; ExtIRQ = 0;
      test_reset();
      test_undef_entry();
      test_irq_entry();
      test_eret();
      test_nested_lockup();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
